// File: rtl/pwm_csr_bank_if.sv
// Byte-level link between the SPI slave and the PWM register bank.
interface pwm_csr_bank_if;
  logic       frame_active;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [7:0] tx_data;
  logic       tx_load;

  modport master (
    output frame_active, rx_data, rx_valid,
    input  tx_data, tx_load
  );

  modport slave (
    input  frame_active, rx_data, rx_valid,
    output tx_data, tx_load
  );
endinterface

// File: rtl/pwm_csr_bank.sv
// Byte-framed DUTY/CTRL register bank driving NUM_CH PWM outputs from one shared counter.
// Define PWM_SYNC_UPDATE_EN to defer DUTY writes to the next counter wrap.
module pwm_csr_bank #(
  parameter int unsigned NUM_CH = 7,
  parameter int unsigned CNT_W  = 15
) (
  input  logic              sys_clk,
  input  logic              rst_n,
  pwm_csr_bank_if.slave     bus,
  output logic              err,
  output logic [NUM_CH-1:0] pwm_out
);

  typedef enum logic [2:0] {StCmd, StWrHi, StWrLo, StRdLo, StDone} state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [15:0]       duty_q [NUM_CH];
  logic [15:0]       duty_d [NUM_CH];
  logic [15:0]       duty_rd [NUM_CH];
  logic [NUM_CH-1:0] en_q, en_d, inv_q, inv_d;
  logic [2:0]        chan_q, chan_d;
  logic [1:0]        sel_q, sel_d;
  logic              ok_q, ok_d;
  logic [7:0]        shadow_q, shadow_d;
  logic [7:0]        tx_data_q, tx_data_d;
  logic              tx_load_q, tx_load_d;
  logic              err_q, err_d;
  logic [NUM_CH-1:0] pwm_q, pwm_d;

  logic              accept;
  logic [2:0]        rd_chan;
  logic [1:0]        rd_sel;
  logic              rd_ok;
  logic [15:0]       rd_word;
  logic [15:0]       wr_word;
  logic [NUM_CH-1:0] duty_we, ctrl_we;

`ifdef PWM_SYNC_UPDATE_EN
  logic [15:0]       pend_q [NUM_CH];
  logic [15:0]       pend_d [NUM_CH];
  logic              wrap;
  assign wrap = (cnt_q == {CNT_W{1'b1}});
`endif

  function automatic logic tgt_ok(logic [2:0] ch, logic [1:0] sel);
    return (32'(ch) < NUM_CH) && !sel[1];
  endfunction

  assign accept = bus.rx_valid & bus.frame_active;
  assign cnt_d  = cnt_q + CNT_W'(1);

  // Reads see the pending value when deferred updates are enabled.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
`ifdef PWM_SYNC_UPDATE_EN
      duty_rd[i] = pend_q[i];
`else
      duty_rd[i] = duty_q[i];
`endif
    end
  end

  // Command byte addresses the read directly; the low byte reuses the latched target.
  always_comb begin
    rd_chan = (state_q == StCmd) ? bus.rx_data[4:2] : chan_q;
    rd_sel  = (state_q == StCmd) ? bus.rx_data[1:0] : sel_q;
    rd_ok   = tgt_ok(rd_chan, rd_sel);
    rd_word = '0;
    if (rd_ok) begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (rd_chan == 3'(i)) begin
          rd_word = rd_sel[0] ? {14'd0, inv_q[i], en_q[i]} : duty_rd[i];
        end
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    chan_d    = chan_q;
    sel_d     = sel_q;
    ok_d      = ok_q;
    shadow_d  = shadow_q;
    tx_data_d = tx_data_q;
    tx_load_d = 1'b0;
    err_d     = err_q;
    duty_we   = '0;
    ctrl_we   = '0;
    wr_word   = {shadow_q, bus.rx_data};
    if (!bus.frame_active) begin
      state_d = StCmd;
    end else if (accept) begin
      unique case (state_q)
        StCmd: begin
          chan_d = bus.rx_data[4:2];
          sel_d  = bus.rx_data[1:0];
          ok_d   = rd_ok;
          if (!rd_ok) err_d = 1'b1;
          if (bus.rx_data[7]) begin
            state_d = StWrHi;
          end else begin
            tx_data_d = rd_word[15:8];
            tx_load_d = 1'b1;
            state_d   = StRdLo;
          end
        end
        StWrHi: begin
          shadow_d = bus.rx_data;
          state_d  = StWrLo;
        end
        StWrLo: begin
          if (ok_q) begin
            for (int i = 0; i < NUM_CH; i++) begin
              if (chan_q == 3'(i)) begin
                if (sel_q[0]) ctrl_we[i] = 1'b1;
                else          duty_we[i] = 1'b1;
              end
            end
          end
          state_d = StDone;
        end
        StRdLo: begin
          tx_data_d = rd_word[7:0];
          tx_load_d = 1'b1;
          state_d   = StDone;
        end
        StDone:  state_d = StDone;
        default: state_d = StCmd;
      endcase
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      en_d[i]  = ctrl_we[i] ? bus.rx_data[0] : en_q[i];
      inv_d[i] = ctrl_we[i] ? bus.rx_data[1] : inv_q[i];
`ifdef PWM_SYNC_UPDATE_EN
      // A commit in the wrap cycle lands in pend and waits for the next wrap.
      pend_d[i] = duty_we[i] ? wr_word : pend_q[i];
      duty_d[i] = wrap ? pend_q[i] : duty_q[i];
`else
      duty_d[i] = duty_we[i] ? wr_word : duty_q[i];
`endif
      pwm_d[i] = en_q[i] & (inv_q[i] ^ (16'(cnt_q) < duty_q[i]));
    end
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StCmd;
      cnt_q     <= '0;
      en_q      <= '0;
      inv_q     <= '0;
      chan_q    <= '0;
      sel_q     <= '0;
      ok_q      <= 1'b0;
      shadow_q  <= '0;
      tx_data_q <= '0;
      tx_load_q <= 1'b0;
      err_q     <= 1'b0;
      pwm_q     <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        duty_q[i] <= '0;
`ifdef PWM_SYNC_UPDATE_EN
        pend_q[i] <= '0;
`endif
      end
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      en_q      <= en_d;
      inv_q     <= inv_d;
      chan_q    <= chan_d;
      sel_q     <= sel_d;
      ok_q      <= ok_d;
      shadow_q  <= shadow_d;
      tx_data_q <= tx_data_d;
      tx_load_q <= tx_load_d;
      err_q     <= err_d;
      pwm_q     <= pwm_d;
      for (int i = 0; i < NUM_CH; i++) begin
        duty_q[i] <= duty_d[i];
`ifdef PWM_SYNC_UPDATE_EN
        pend_q[i] <= pend_d[i];
`endif
      end
    end
  end

  assign bus.tx_data = tx_data_q;
  assign bus.tx_load = tx_load_q;
  assign err         = err_q;
  assign pwm_out     = pwm_q;

endmodule

// File: doc/pwm_csr_bank.md
Name: pwm_csr_bank

Overview:
- Parametrised successor to the single-channel SPI-to-PWM core logic.
- Decodes a byte-framed command stream from the SPI block and gives read/write access to per-channel DUTY and CTRL registers for NUM_CH PWM channels.
- Drives NUM_CH registered PWM outputs from one shared free-running counter.
- Sits between the SPI slave byte interface and the chip output pins.

Parameters:
- NUM_CH, 7, number of PWM channels, 1..8; channel address is 3 bits.
- CNT_W, 15, width of the free-running PWM counter, 1..16; PWM period is 2^CNT_W sys_clk cycles.

Ports:
- sys_clk  in  1  single system clock; all logic is on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- frame_active  in  1  high while the SPI chip-select is asserted; a low level ends the frame.
- rx_data  in  8  received byte; valid only when rx_valid=1.
- rx_valid  in  1  one-cycle strobe per received byte, already synchronised to sys_clk.
- tx_data  out  8  byte for the SPI block to shift out next.
- tx_load  out  1  one-cycle strobe; tx_data is valid and must be latched by the SPI block.
- err  out  1  sticky access-error flag.
- pwm_out  out  NUM_CH  PWM outputs; bit i is channel i.

Behaviour:
- Reset (rst_n=0, asynchronous): state=S_CMD; counter=0; all DUTY=0; all CTRL=0; tx_data=0; tx_load=0; err=0; pwm_out=0.
- Counter: increments every cycle and wraps from 2^CNT_W-1 to 0.
- PWM output: pwm_out[i] <= EN[i] & (INV[i] ^ (counter < DUTY[i])).
  - Compare is unsigned, with counter zero-extended to 16 bits; output is registered (1-cycle latency).
  - DUTY=0 gives constant low; DUTY>=2^CNT_W gives constant high (before INV).
  - EN=0 forces the output to 0 regardless of INV.
- Command byte format:
  - bit7: 1=write, 0=read.
  - bits[6:5]: ignored.
  - bits[4:2]: channel.
  - bits[1:0]: register select. 00=DUTY (16b); 01=CTRL (bit0 EN, bit1 INV, other bits read 0); 10/11 reserved.
- Data order: two data bytes follow the command, MSB first.
- Bytes are accepted only when rx_valid & frame_active; rx_valid with frame_active=0 is ignored.
- State machine:
  - S_CMD: on an accepted byte, latch channel/select/direction. Write goes to S_WR_HI. Read loads tx_data=high byte of the target, pulses tx_load the next cycle, and goes to S_RD_LO.
  - S_WR_HI: on an accepted byte, store it in the shadow high byte; go to S_WR_LO.
  - S_WR_LO: on an accepted byte, commit {shadow, byte} as one 16-bit update in the same edge; go to S_DONE. A CTRL write keeps only bits[1:0] of the low byte.
  - S_RD_LO: on an accepted (dummy) byte, tx_data=low byte and tx_load pulses the next cycle; go to S_DONE.
  - S_DONE: further bytes are ignored until the frame ends. No auto-increment.
- frame_active=0 in any state: next state is S_CMD. A partial write (only the high byte received) is discarded and no register changes.
- Invalid target (channel>=NUM_CH or select 1x):
  - Write completes its byte sequence but changes nothing.
  - Read returns 0x00, 0x00.
  - err is set on the command byte.
- err clears only on reset.
- Read data is sampled at the command byte for the high byte and at the second byte for the low byte; no atomic snapshot.
- tx_load is at most one cycle per accepted byte and is low otherwise; tx_data holds its value between loads.
- A register write and a counter wrap in the same cycle: the new value applies per the Optional Feature rule.

Optional Feature:
- PWM_SYNC_UPDATE_EN defined:
  - A committed DUTY write goes to a per-channel pending register and is copied into the active DUTY on the cycle the counter wraps to 0, so there are no mid-period glitches.
  - A write committed in the wrap cycle itself waits for the next wrap.
  - A DUTY read returns the pending value.
  - CTRL updates immediately.
- PWM_SYNC_UPDATE_EN undefined: DUTY updates immediately at commit; there is no pending register.

Test Plan:
- Reset check: with rst_n low, all outputs are 0. Release reset and hold 10 cycles: pwm_out=0 and counter runs.
- Write then read: frame with bytes 0x84 (write, ch1, DUTY), 0x40, 0x00, then CTRL write 0x85, 0x00, 0x01. Then a read frame 0x04, dummy, dummy returns tx_data 0x40 then 0x00 with one tx_load each. With CNT_W=15, pwm_out[1] is high for 0x4000 of 0x8000 cycles.
- Boundaries, EN=1: DUTY=0x0000 gives constant low. DUTY=0xFFFF gives constant high. INV=1 with DUTY=0 gives constant high. EN=0 with INV=1 gives 0.
- Abort mid-write: 0x80, 0x12, then frame_active drops. DUTY0 is unchanged. The next frame parses its first byte as a command.
- Invalid target: write to channel 7 with NUM_CH=7, then read select 10. err=1, read bytes are 0x00, 0x00, no register changes, and err stays set across frames.
- With PWM_SYNC_UPDATE_EN: a DUTY write mid-period leaves the output unchanged until the counter wraps, then the new duty applies. Without the macro, the new duty applies on the cycle after commit.
